// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared select encodings and widths for the multi-cycle datapath
package mc_pkg;

    localparam int WL_DEF = 32;

    // Same encodings as the 3:1 datapath select muxes.
    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b01;
    localparam logic [1:0] SEL_C   = 2'b10;
    localparam logic [1:0] SEL_ILL = 2'b11;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic sel_legal(input logic [1:0] sel);
        return sel != SEL_ILL;
    endfunction

endpackage

// File: rtl/dest_slot.sv
// rtl/dest_slot.sv - one-entry holding register with fill/drain handshake
module dest_slot
    import mc_pkg::*;
#(
    parameter int WL = WL_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fill,
    input  logic [WL-1:0] din,
    input  logic          ready,
    output logic          valid,
    output logic [WL-1:0] dout
);

    slot_state_t state;

    // A fill while draining replaces the word in place, so valid never bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
            dout  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (fill) begin
                        state <= SLOT_FULL;
                        dout  <= din;
                    end
                end
                SLOT_FULL: begin
                    if (fill) begin
                        dout <= din;
                    end else if (ready) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/demux_13_slot.sv
// rtl/demux_13_slot.sv - registered 1-to-3 result distributor with illegal-select drop accounting
module demux_13_slot
    import mc_pkg::*;
#(
    parameter int WL    = WL_DEF,
    parameter int CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 Rst_n,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    input  logic [1:0]           Sel,
    input  logic signed [WL-1:0] In,
    output logic signed [WL-1:0] A_Out,
    output logic signed [WL-1:0] B_Out,
    output logic signed [WL-1:0] C_Out,
    output logic                 A_Valid,
    output logic                 B_Valid,
    output logic                 C_Valid,
    input  logic                 A_Ready,
    input  logic                 B_Ready,
    input  logic                 C_Ready,
    output logic                 Err,
    input  logic                 Err_Clr,
    output logic [CNT_W-1:0]     Drop_Cnt
);

    logic xfer;
    logic fill_a, fill_b, fill_c;
    logic drop;

    // Only the targeted slot can stall upstream; illegal words are always taken.
    always_comb begin
        In_Ready = 1'b1;
        case (Sel)
            SEL_A:   In_Ready = !A_Valid || A_Ready;
            SEL_B:   In_Ready = !B_Valid || B_Ready;
            SEL_C:   In_Ready = !C_Valid || C_Ready;
            default: In_Ready = 1'b1;
        endcase
    end

    assign xfer   = In_Valid && In_Ready;
    assign fill_a = xfer && (Sel == SEL_A);
    assign fill_b = xfer && (Sel == SEL_B);
    assign fill_c = xfer && (Sel == SEL_C);
    assign drop   = xfer && !sel_legal(Sel);

    dest_slot #(.WL(WL)) u_slot_a (
        .clk   (CLK),
        .rst_n (Rst_n),
        .fill  (fill_a),
        .din   (In),
        .ready (A_Ready),
        .valid (A_Valid),
        .dout  (A_Out)
    );

    dest_slot #(.WL(WL)) u_slot_b (
        .clk   (CLK),
        .rst_n (Rst_n),
        .fill  (fill_b),
        .din   (In),
        .ready (B_Ready),
        .valid (B_Valid),
        .dout  (B_Out)
    );

    dest_slot #(.WL(WL)) u_slot_c (
        .clk   (CLK),
        .rst_n (Rst_n),
        .fill  (fill_c),
        .din   (In),
        .ready (C_Ready),
        .valid (C_Valid),
        .dout  (C_Out)
    );

    // A drop in the same cycle as a clear wins and restarts the count at one.
    always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            Err      <= 1'b0;
            Drop_Cnt <= '0;
        end else if (drop) begin
            Err <= 1'b1;
            if (Err_Clr) begin
                Drop_Cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!(&Drop_Cnt)) begin
                Drop_Cnt <= Drop_Cnt + 1'b1;
            end
        end else if (Err_Clr) begin
            Err      <= 1'b0;
            Drop_Cnt <= '0;
        end
    end

endmodule

// File: tb/tb_demux_13_slot.sv
// tb/tb_demux_13_slot.sv - randomized and directed bench for demux_13_slot against a slot-level model
module tb_demux_13_slot;

    logic               CLK;
    logic               Rst_n;
    logic               In_Valid;
    logic               In_Ready;
    logic [1:0]         Sel;
    logic signed [31:0] In;
    logic signed [31:0] A_Out, B_Out, C_Out;
    logic               A_Valid, B_Valid, C_Valid;
    logic               A_Ready, B_Ready, C_Ready;
    logic               Err;
    logic               Err_Clr;
    logic [7:0]         Drop_Cnt;

    int n_tests = 0;
    int n_fail  = 0;

    demux_13_slot #(.WL(32), .CNT_W(8)) dut (
        .CLK      (CLK),
        .Rst_n    (Rst_n),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .Sel      (Sel),
        .In       (In),
        .A_Out    (A_Out),
        .B_Out    (B_Out),
        .C_Out    (C_Out),
        .A_Valid  (A_Valid),
        .B_Valid  (B_Valid),
        .C_Valid  (C_Valid),
        .A_Ready  (A_Ready),
        .B_Ready  (B_Ready),
        .C_Ready  (C_Ready),
        .Err      (Err),
        .Err_Clr  (Err_Clr),
        .Drop_Cnt (Drop_Cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: three slots, each either holding a word or not, plus error and drop count.
    logic        m_full [3];
    logic [31:0] m_data [3];
    logic        m_err;
    int          m_cnt;

    function automatic logic slot_rdy(input int i);
        return (i == 0) ? A_Ready : (i == 1) ? B_Ready : C_Ready;
    endfunction

    function automatic logic model_in_ready();
        if (Sel == 2'b11) return 1'b1;
        return !m_full[Sel] || slot_rdy(int'(Sel));
    endfunction

    always @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_full[i] <= 1'b0;
                m_data[i] <= '0;
            end
            m_err <= 1'b0;
            m_cnt <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (In_Valid && model_in_ready() && Sel == 2'(i)) begin
                    m_full[i] <= 1'b1;
                    m_data[i] <= In;
                end else if (m_full[i] && slot_rdy(i)) begin
                    m_full[i] <= 1'b0;
                end
            end
            if (In_Valid && Sel == 2'b11) begin
                m_err <= 1'b1;
                m_cnt <= Err_Clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            end else if (Err_Clr) begin
                m_err <= 1'b0;
                m_cnt <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("in_ready", 32'(In_Ready), 32'(model_in_ready()));
        chk("a_valid",  32'(A_Valid),  32'(m_full[0]));
        chk("b_valid",  32'(B_Valid),  32'(m_full[1]));
        chk("c_valid",  32'(C_Valid),  32'(m_full[2]));
        chk("a_out",    A_Out,         m_data[0]);
        chk("b_out",    B_Out,         m_data[1]);
        chk("c_out",    C_Out,         m_data[2]);
        chk("err",      32'(Err),      32'(m_err));
        chk("drop_cnt", 32'(Drop_Cnt), 32'(m_cnt));
    end

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic ar, input logic br, input logic cr, input logic clr);
        In_Valid = v;
        Sel      = s;
        In       = d;
        A_Ready  = ar;
        B_Ready  = br;
        C_Ready  = cr;
        Err_Clr  = clr;
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    logic acc;

    initial begin
        Rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("rst_a_valid", 32'(A_Valid), 0);
        chk("rst_drop", 32'(Drop_Cnt), 0);
        cycle();
        Rst_n = 1'b1;
        cycle();

        // Single routing of a negative word to B.
        drive(1, 2'b01, -32'sd5, 0, 0, 0, 0);
        @(negedge CLK);
        chk("route_ready", 32'(In_Ready), 1);
        cycle();
        drive(0, 2'b01, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("route_b_out", B_Out, 32'hFFFF_FFFB);
        chk("route_b_valid", 32'(B_Valid), 1);
        chk("route_a_valid", 32'(A_Valid), 0);
        chk("route_c_valid", 32'(C_Valid), 0);
        chk("route_a_out", A_Out, 0);
        chk("route_c_out", C_Out, 0);
        cycle();
        drive(0, 2'b00, 0, 0, 1, 0, 0);
        cycle();

        // Stalled A must not block C.
        drive(1, 2'b00, 32'd11, 0, 0, 0, 0);
        cycle();
        drive(1, 2'b00, 32'd22, 0, 0, 0, 0);
        @(negedge CLK);
        chk("bp_a_stall", 32'(In_Ready), 0);
        cycle();
        drive(1, 2'b10, 32'd7, 0, 0, 0, 0);
        @(negedge CLK);
        chk("bp_c_ready", 32'(In_Ready), 1);
        cycle();
        drive(0, 2'b10, 0, 0, 0, 1, 0);
        @(negedge CLK);
        chk("bp_c_out", C_Out, 32'd7);
        chk("bp_a_out", A_Out, 32'd11);
        chk("bp_a_valid", 32'(A_Valid), 1);
        cycle();

        // Drain and fill of A in one cycle.
        drive(1, 2'b00, 32'd3, 1, 0, 0, 0);
        cycle();
        drive(1, 2'b00, 32'd9, 1, 0, 0, 0);
        @(negedge CLK);
        chk("df_ready", 32'(In_Ready), 1);
        chk("df_a_out_old", A_Out, 32'd3);
        cycle();
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("df_a_out", A_Out, 32'd9);
        chk("df_a_valid", 32'(A_Valid), 1);

        // Three illegal accepts, then clear.
        cycle();
        drive(1, 2'b11, 32'd55, 0, 0, 0, 0);
        repeat (3) cycle();
        drive(0, 2'b11, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("ill_err", 32'(Err), 1);
        chk("ill_cnt", 32'(Drop_Cnt), 3);
        chk("ill_a_out", A_Out, 32'd9);
        cycle();
        drive(0, 2'b11, 0, 0, 0, 0, 1);
        cycle();
        drive(0, 2'b11, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("clr_err", 32'(Err), 0);
        chk("clr_cnt", 32'(Drop_Cnt), 0);

        // Saturation, then clear racing an illegal accept.
        cycle();
        drive(1, 2'b11, 32'd1, 0, 0, 0, 0);
        repeat (300) cycle();
        @(negedge CLK);
        chk("sat_cnt", 32'(Drop_Cnt), 255);
        chk("sat_err", 32'(Err), 1);
        cycle();
        drive(1, 2'b11, 32'd1, 0, 0, 0, 1);
        cycle();
        drive(0, 2'b11, 0, 0, 0, 0, 0);
        @(negedge CLK);
        chk("clrdrop_err", 32'(Err), 1);
        chk("clrdrop_cnt", 32'(Drop_Cnt), 1);

        // Asynchronous reset with A full: outputs clear without a clock edge.
        cycle();
        drive(1, 2'b10, 32'd44, 0, 0, 0, 0);
        Rst_n = 1'b0;
        #1;
        chk("arst_a_valid", 32'(A_Valid), 0);
        chk("arst_a_out", A_Out, 0);
        chk("arst_c_out", C_Out, 0);
        chk("arst_err", 32'(Err), 0);
        chk("arst_cnt", 32'(Drop_Cnt), 0);
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        cycle();
        Rst_n = 1'b1;
        cycle();

        // Random traffic, holding an offered word until it is taken.
        acc = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            if (!In_Valid || acc) begin
                In_Valid = ($urandom_range(0, 3) != 0);
                Sel      = 2'($urandom_range(0, 3));
                In       = $urandom;
            end
            A_Ready = $urandom_range(0, 1) == 1;
            B_Ready = $urandom_range(0, 2) == 0;
            C_Ready = $urandom_range(0, 3) != 0;
            Err_Clr = $urandom_range(0, 30) == 0;
            @(negedge CLK);
            acc = In_Ready;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_13_slot.md
# demux_13_slot

Registered 1-to-3 result distributor: the write-side counterpart of the datapath's 3:1 select muxes. It accepts one signed word per handshake from the multi-cycle datapath, steers it by a 2-bit select into one of three one-entry holding slots (A, B, C), and presents each slot to its consumer under its own valid/ready handshake. Select `2'b11` is illegal. An illegal word is consumed and dropped, and the drop is recorded in a sticky error flag and a saturating counter.

## Interface
- `WL`, default 32: data word width; signed.
- `CNT_W`, default 8: width of the drop counter.

- `CLK` input 1: single clock; everything is rising-edge.
- `Rst_n` input 1: asynchronous, active-low reset.
- `In_Valid` input 1: upstream word valid.
- `In_Ready` output 1: block accepts the word this cycle.
- `Sel` input 2: destination. `00`=A, `01`=B, `10`=C, `11`=illegal.
- `In` input WL: signed data word.
- `A_Out`, `B_Out`, `C_Out` output WL each: slot contents, signed.
- `A_Valid`, `B_Valid`, `C_Valid` output 1 each: slot holds an undelivered word.
- `A_Ready`, `B_Ready`, `C_Ready` input 1 each: consumer takes the slot word.
- `Err` output 1: sticky; set on any accepted illegal select.
- `Err_Clr` input 1: synchronous clear of `Err` and `Drop_Cnt`.
- `Drop_Cnt` output CNT_W: count of dropped words; saturates at all-ones.

## Operation
- **Upstream transfer:** an upstream transfer occurs when `In_Valid & In_Ready`.
- **Upstream stability:** upstream holds `In` and `Sel` stable while `In_Valid` is high and not yet accepted.
- **`In_Ready` for a legal `Sel`:** `In_Ready = !X_Valid | X_Ready`, where X is the selected slot. This is a combinational path from `X_Ready`.
- **`In_Ready` for illegal `Sel`:** `In_Ready = 1`. The word is discarded and no slot changes.
- **Slot fill:** on a transfer to slot X, `X_Out <= In` and `X_Valid <= 1`.
- **Slot drain:** on `X_Valid & X_Ready` with no fill into X, `X_Valid <= 0`. `X_Out` holds its last value.
- **Simultaneous drain and fill of the same slot:** the new word replaces the old and `X_Valid` stays 1. There is no bubble.
- **Slot independence:** slots are independent. A full, stalled slot never blocks transfers to the other slots.
- **Illegal accept:** `Err <= 1` and `Drop_Cnt <= Drop_Cnt + 1`. The counter holds when it is all-ones.
- **`Err_Clr`:** `Err <= 0` and `Drop_Cnt <= 0`. When `Err_Clr` coincides with an illegal accept, the result is `Err = 1` and `Drop_Cnt = 1`.
- **Arithmetic:** data is passed through bit-exact. No sign extension or width change.

## Timing
- **Reset values (async assert):**
  - All `X_Valid` = 0.
  - All `X_Out` = 0.
  - `Err` = 0.
  - `Drop_Cnt` = 0.
- **Reset release:** synchronized to `CLK` by the system; the block is ready the first edge after deassertion.
- **Latency:** a word accepted at edge N appears on `X_Out` with `X_Valid = 1` after edge N.
- **Throughput:** one word per cycle into any slot whose consumer keeps `X_Ready = 1`. With three ready consumers this is full rate.
- **Reset mid-operation:** all held words are lost with no partial state, and `Err`/`Drop_Cnt` are cleared.
- **Slot state machine (per slot):**
  - EMPTY -(fill)-> FULL.
  - FULL -(drain, no fill)-> EMPTY.
  - FULL -(fill & drain)-> FULL.
  - FULL -(no drain)-> FULL. Upstream is stalled only if it targets this slot.
- **Ready gating:** `X_Ready` while `X_Valid = 0` has no effect.

## Structure
- **Shared package `mc_pkg`:**
  - `SEL_A = 2'b00`, `SEL_B = 2'b01`, `SEL_C = 2'b10`, `SEL_ILL = 2'b11`.
  - Default `WL`.
  - These encodings match the 3:1 datapath muxes.
- **Sub-module `dest_slot #(WL)`:** one-entry holding register with fill/drain handshake; instantiated three times.
- **Top level contents:** decode, `In_Ready` mux, and error/counter logic.

## Test plan
- **Reset:** assert `Rst_n = 0` mid-traffic with A full -> all `Valid`, `Out`, `Err` and `Drop_Cnt` read 0 immediately, with no clock needed.
- **Single routing:** `In = -5`, `Sel = 01`, `B_Ready = 0` -> `B_Out = -5` and `B_Valid = 1` one cycle later. A and C stay 0 and invalid.
- **Backpressure isolation:**
  - Setup: fill A with `A_Ready = 0`.
  - Stimulus: offer `Sel = 00` -> `In_Ready = 0`. Then offer `Sel = 10`, `In = 7`.
  - Response: `In_Ready = 1` and `C_Out = 7`. A unchanged.
- **Simultaneous drain and fill:**
  - Setup: A holds 3, `A_Ready = 1`.
  - Stimulus: offer `Sel = 00`, `In = 9`.
  - Response: accepted, `A_Out = 9`, and `A_Valid` never drops.
- **Illegal select:**
  - Stimulus: `Sel = 11` for 3 accepts.
  - Response: `Err = 1` and `Drop_Cnt = 3`, with no slot change. Then `Err_Clr` -> `Err = 0` and `Drop_Cnt = 0`.
- **Saturation:** 300 illegal accepts with `CNT_W = 8` -> `Drop_Cnt = 255`. `Err_Clr` together with an illegal accept -> `Err = 1` and `Drop_Cnt = 1`.
